adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable SPI responder modelling the 8-channel, 12-bit SAR ADC (MCP3208-style protocol) that the oscillator's ADC SPI initiator talks to.
- Lets the oscillator top be closed-loop tested and run on hardware with no physical ADC.
- Oversamples the initiator's adc_cs/adc_clk/adc_si in the system clock domain, decodes the start/command bits, and shifts the selected channel's 12-bit value out on adc_so.
- Channel values come from a parallel input bus driven by the bench or by on-chip test logic.

Parameters:
- DW, 12, sample width in bits returned per conversion.
- SYNC_STAGES, 2, synchronizer flops on adc_cs, adc_clk and adc_si (minimum 2).

Ports:
- clk  in  1  system clock (48 MHz).
- reset  in  1  synchronous, active-low reset; 0 = reset.
- adc_cs  in  1  SPI chip select from initiator, active low.
- adc_clk  in  1  SPI clock from initiator, mode 0 (idle low).
- adc_si  in  1  SPI data from initiator (command bits).
- adc_so  out  1  SPI data to initiator.
- ch_data  in  8*DW  channel values; channel n at bits [n*DW +: DW].
- cmd_valid  out  1  one-clk pulse when a complete command is decoded.
- cmd_sgl  out  1  SGL/DIFF bit of the last command.
- cmd_chan  out  3  D2..D0 of the last command.

Behaviour:
- Reset (reset=0 at posedge clk):
  - state=IDLE.
  - adc_so=0, cmd_valid=0, cmd_sgl=0, cmd_chan=0.
  - Synchronizers load cs=1, clk=0, si=0.
- Synchronization and edge detection:
  - Inputs pass through SYNC_STAGES flops, plus one more stage for edge detect.
  - sck_rise/sck_fall are one-clk pulses.
  - Requirement on the initiator: adc_clk high and low phases are each at least 4 clk periods.
- cs_n deasserted (sync high): state goes to IDLE and adc_so=0 on the next clk, from any state. This includes mid-command and mid-data.
- States:
  - IDLE: on sync cs low, go to WAIT_START.
  - WAIT_START: on sck_rise with si=1, go to CMD with bit count 0. Leading zeros (si=0) are ignored.
  - CMD: on each sck_rise, shift si into {sgl,d2,d1,d0} (4 bits, MSB first). On the 4th bit:
    - latch sample = ch_data[chan] into a DW-bit shift register;
    - update cmd_sgl/cmd_chan;
    - pulse cmd_valid for one clk;
    - go to NULL.
  - NULL: on sck_fall, drive adc_so=0 (null bit) and go to DATA with count=DW-1.
  - DATA: on each sck_fall, drive adc_so=sample[count]. B11 is driven first. After the B0 falling edge, go to TRAIL.
  - TRAIL: on each sck_fall, drive adc_so=0 (optional feature alters this). Stays here until cs deasserts.
- adc_so changes only on sck_fall (or cs deassert/reset). Latency is 1 clk after the detected sck_fall, i.e. SYNC_STAGES+2 clk after the pad edge.
- Sample value is frozen at latch time; ch_data changes during DATA do not affect the current word.
- Differential mode (sgl=0): returns ch_data[chan] unchanged. The difference is not computed; cmd_sgl reports the mode.
- Command bits are never sampled on sck_fall, and data is never driven on sck_rise.
- A new conversion requires a cs high→low cycle; extra sck edges in TRAIL never restart a command.

Optional Feature:
- Macro: ADC_RESP_LSB_TRAIL_EN.
- Defined: in TRAIL, the next DW-1 sck_fall edges drive B1..B(DW-1), LSB-first (B0 not repeated, as on the real part). After that, adc_so=0.
- Undefined: TRAIL always drives 0. The trailing counter logic is not built.

Decomposition:
- Shared package (adc_spi_pkg) holds:
  - state encoding constants (IDLE, WAIT_START, CMD, NULL, DATA, TRAIL);
  - CMD_BITS=4, NUM_CH=8, DEF_DW=12.
- The initiator in the oscillator uses the same constants.
- Natural sub-module: spi_in_sync, a SYNC_STAGES synchronizer plus edge detector for the three SPI inputs with parameterized reset values. The FSM and shift register remain in adc_spi_responder.

Test Plan:
- Reset held low 10 clk with adc_cs=0 and toggling adc_clk → adc_so=0, cmd_valid=0 throughout; state IDLE after release with cs high.
- ch_data[1]=12'h001, send start=1, sgl=1, chan=3'b001, then 13 more clocks → cmd_valid pulses once with cmd_chan=1, cmd_sgl=1. adc_so reads null=0 then 000000000001.
- ch_data[7]=12'hA5C, two leading zeros before start, chan=7 → leading zeros ignored; adc_so returns 1010_0101_1100 MSB first.
- cs deasserted after 5 of 12 data bits, then new command chan=2 with ch_data[2]=12'h3FF → adc_so=0 within SYNC_STAGES+2 clk of cs high; second transfer returns 12'h3FF intact.
- ch_data[0] changed from 12'h800 to 12'h001 during the DATA phase → transfer still returns 12'h800.
- 24 data clocks after the null bit, ch_data[4]=12'h801 → with ADC_RESP_LSB_TRAIL_EN: MSB-first word, then 0,0,0,0,0,0,0,0,0,0,1 (B1..B11), then 0; without the macro, all 0 after B0.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared constants and state encoding for the ADC SPI link
//
// Purpose: constants common to the ADC SPI responder and the oscillator's
// ADC SPI initiator, so both sides agree on command length, channel count,
// default sample width and FSM state encoding.
// Ports: none (package).
package adc_spi_pkg;

  localparam int CMD_BITS = 4;   // {sgl, d2, d1, d0} after the start bit
  localparam int NUM_CH   = 8;
  localparam int DEF_DW   = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_CMD        = 3'd2,
    ST_NULL       = 3'd3,
    ST_DATA       = 3'd4,
    ST_TRAIL      = 3'd5
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizer and sck edge detector for the SPI inputs
//
// Purpose: brings adc_cs, adc_clk and adc_si into the clk domain through
// STAGES flops each, then derives registered one-clk sck_rise/sck_fall
// pulses from one further delay stage on the clock line.
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   adc_cs/clk/si     raw SPI pad inputs
//   cs_s, si_s        synchronized chip select and data levels
//   sck_rise/sck_fall one-clk pulses on synchronized SPI clock edges
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic CS_RST  = 1'b1,
  parameter logic SCK_RST = 1'b0,
  parameter logic SI_RST  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic adc_cs,
  input  logic adc_clk,
  input  logic adc_si,
  output logic cs_s,
  output logic si_s,
  output logic sck_rise,
  output logic sck_fall
);

  logic [STAGES-1:0] cs_q, cs_d;
  logic [STAGES-1:0] sck_q, sck_d;
  logic [STAGES-1:0] si_q, si_d;
  logic              sck_dly_q, sck_dly_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    cs_d      = {cs_q[STAGES-2:0], adc_cs};
    sck_d     = {sck_q[STAGES-2:0], adc_clk};
    si_d      = {si_q[STAGES-2:0], adc_si};
    sck_dly_d = sck_q[STAGES-1];
    // Edge pulses are registered so downstream logic sees clean one-clk strobes.
    rise_d    = sck_q[STAGES-1] & ~sck_dly_q;
    fall_d    = ~sck_q[STAGES-1] & sck_dly_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_q      <= {STAGES{CS_RST}};
      sck_q     <= {STAGES{SCK_RST}};
      si_q      <= {STAGES{SI_RST}};
      sck_dly_q <= SCK_RST;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      si_q      <= si_d;
      sck_dly_q <= sck_dly_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign cs_s     = cs_q[STAGES-1];
  assign si_s     = si_q[STAGES-1];
  assign sck_rise = rise_q;
  assign sck_fall = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - MCP3208-style 8-channel 12-bit SAR ADC SPI responder
//
// Purpose: stands in for the physical ADC. Oversamples the initiator's SPI
// lines, decodes start + {sgl,d2,d1,d0}, then returns a null bit followed by
// the selected channel's DW-bit value MSB first on adc_so (changes on sck fall).
// Optional macro ADC_RESP_LSB_TRAIL_EN: after B0, the following DW-1 falling
// edges return B1..B(DW-1) LSB first, then 0; without it the trail is all 0.
// Ports:
//   clk, reset      system clock, synchronous active-low reset (0 = reset)
//   adc_cs          SPI chip select, active low
//   adc_clk         SPI clock, mode 0
//   adc_si          SPI command data from initiator
//   adc_so          SPI data to initiator
//   ch_data         channel values, channel n at [n*DW +: DW]
//   cmd_valid       one-clk pulse when a command has been decoded
//   cmd_sgl         SGL/DIFF bit of the last command
//   cmd_chan        channel field of the last command
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_cs,
  input  logic                 adc_clk,
  input  logic                 adc_si,
  output logic                 adc_so,
  input  logic [NUM_CH*DW-1:0] ch_data,
  output logic                 cmd_valid,
  output logic                 cmd_sgl,
  output logic [2:0]           cmd_chan
);

  localparam int CNT_W = $clog2(DW);
  localparam logic [1:0] CMD_LAST = 2'(CMD_BITS - 1);

  logic cs_s, si_s, sck_rise, sck_fall;

  spi_in_sync #(
    .STAGES  (SYNC_STAGES),
    .CS_RST  (1'b1),
    .SCK_RST (1'b0),
    .SI_RST  (1'b0)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .adc_cs   (adc_cs),
    .adc_clk  (adc_clk),
    .adc_si   (adc_si),
    .cs_s     (cs_s),
    .si_s     (si_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  state_t          state_q, state_d;
  logic [1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      cmd_sr_q, cmd_sr_d;
  logic [DW-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            so_q, so_d;
  logic            valid_q, valid_d;
  logic            sgl_q, sgl_d;
  logic [2:0]      chan_q, chan_d;
  logic [3:0]      cmd_full;
`ifdef ADC_RESP_LSB_TRAIL_EN
  // Index of the next trailing bit; 0 means the LSB-first echo is finished.
  logic [CNT_W-1:0] trail_idx_q, trail_idx_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_sr_d  = cmd_sr_q;
    sample_d  = sample_q;
    cnt_d     = cnt_q;
    so_d      = so_q;
    valid_d   = 1'b0;
    sgl_d     = sgl_q;
    chan_d    = chan_q;
    cmd_full  = {cmd_sr_q, si_s};
`ifdef ADC_RESP_LSB_TRAIL_EN
    trail_idx_d = trail_idx_q;
`endif

    // Chip select release aborts whatever is in flight.
    if (cs_s) begin
      state_d = ST_IDLE;
      so_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_START;

        ST_WAIT_START: begin
          if (sck_rise && si_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = 2'd0;
          end
        end

        ST_CMD: begin
          if (sck_rise) begin
            if (bit_cnt_q == CMD_LAST) begin
              // Sample is frozen here; later ch_data changes do not affect this word.
              sample_d = ch_data[cmd_full[2:0]*DW +: DW];
              sgl_d    = cmd_full[3];
              chan_d   = cmd_full[2:0];
              valid_d  = 1'b1;
              state_d  = ST_NULL;
            end else begin
              cmd_sr_d  = {cmd_sr_q[1:0], si_s};
              bit_cnt_d = bit_cnt_q + 2'd1;
            end
          end
        end

        ST_NULL: begin
          if (sck_fall) begin
            so_d    = 1'b0;
            cnt_d   = CNT_W'(DW - 1);
            state_d = ST_DATA;
          end
        end

        ST_DATA: begin
          if (sck_fall) begin
            so_d = sample_q[cnt_q];
            if (cnt_q == '0) begin
              state_d = ST_TRAIL;
`ifdef ADC_RESP_LSB_TRAIL_EN
              trail_idx_d = CNT_W'(1);
`endif
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        ST_TRAIL: begin
          if (sck_fall) begin
`ifdef ADC_RESP_LSB_TRAIL_EN
            if (trail_idx_q != '0) begin
              so_d        = sample_q[trail_idx_q];
              trail_idx_d = (trail_idx_q == CNT_W'(DW - 1)) ? '0 : trail_idx_q + CNT_W'(1);
            end else begin
              so_d = 1'b0;
            end
`else
            so_d = 1'b0;
`endif
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      cmd_sr_q  <= '0;
      sample_q  <= '0;
      cnt_q     <= '0;
      so_q      <= 1'b0;
      valid_q   <= 1'b0;
      sgl_q     <= 1'b0;
      chan_q    <= '0;
`ifdef ADC_RESP_LSB_TRAIL_EN
      trail_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_sr_q  <= cmd_sr_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      so_q      <= so_d;
      valid_q   <= valid_d;
      sgl_q     <= sgl_d;
      chan_q    <= chan_d;
`ifdef ADC_RESP_LSB_TRAIL_EN
      trail_idx_q <= trail_idx_d;
`endif
    end
  end

  assign adc_so    = so_q;
  assign cmd_valid = valid_q;
  assign cmd_sgl   = sgl_q;
  assign cmd_chan  = chan_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed self-checking bench for adc_spi_responder
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int DW   = 12;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 adc_cs = 1'b1;
  logic                 adc_clk = 1'b0;
  logic                 adc_si = 1'b0;
  logic                 adc_so;
  logic [NUM_CH*DW-1:0] ch_data = '0;
  logic                 cmd_valid;
  logic                 cmd_sgl;
  logic [2:0]           cmd_chan;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;

  adc_spi_responder #(.DW(DW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset     (reset),
    .adc_cs    (adc_cs),
    .adc_clk   (adc_clk),
    .adc_si    (adc_si),
    .adc_so    (adc_so),
    .ch_data   (ch_data),
    .cmd_valid (cmd_valid),
    .cmd_sgl   (cmd_sgl),
    .cmd_chan  (cmd_chan)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI clock period: set si, sample so just before the rising edge.
  task automatic sck_cycle(input logic si_b, output logic so_b);
    adc_si = si_b;
    repeat (HALF) @(negedge clk);
    so_b = adc_so;
    adc_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    adc_clk = 1'b0;
  endtask

  task automatic send_cmd(input logic sgl, input logic [2:0] ch, input int lead);
    logic dummy;
    adc_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < lead; i++) sck_cycle(1'b0, dummy);
    sck_cycle(1'b1, dummy);
    sck_cycle(sgl, dummy);
    for (int i = 2; i >= 0; i--) sck_cycle(ch[i], dummy);
  endtask

  // First sample lands in the most significant of the n returned bits.
  task automatic read_bits(input int n, output logic [63:0] v);
    logic b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      sck_cycle(1'b0, b);
      v = {v[62:0], b};
    end
  endtask

  task automatic cs_end();
    adc_cs = 1'b1;
    adc_si = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    logic [63:0] v, v2, exp6;
    logic        b;
    int          v0, bad_so, bad_valid;

    // Reset held with cs low and sck toggling.
    bad_so = 0;
    bad_valid = 0;
    reset = 1'b0;
    adc_cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      adc_clk = ~adc_clk;
      if (adc_so !== 1'b0) bad_so++;
      if (cmd_valid !== 1'b0) bad_valid++;
    end
    check("rst_so_glitches", 64'(bad_so), 64'd0);
    check("rst_valid_glitches", 64'(bad_valid), 64'd0);
    adc_clk = 1'b0;
    adc_cs = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    check("rst_cmd_sgl", 64'(cmd_sgl), 64'd0);
    check("rst_cmd_chan", 64'(cmd_chan), 64'd0);
    check("rst_so", 64'(adc_so), 64'd0);

    // Channel 1, single-ended, value 1.
    ch_data[1*DW +: DW] = 12'h001;
    v0 = valid_cnt;
    send_cmd(1'b1, 3'd1, 0);
    read_bits(13, v);
    check("t1_word", v, 64'h0001);
    check("t1_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    check("t1_cmd_chan", 64'(cmd_chan), 64'd1);
    check("t1_cmd_sgl", 64'(cmd_sgl), 64'd1);
    cs_end();

    // Channel 7 with two leading zeros.
    ch_data[7*DW +: DW] = 12'hA5C;
    v0 = valid_cnt;
    send_cmd(1'b1, 3'd7, 2);
    read_bits(13, v);
    check("t2_word", v, {51'd0, 1'b0, 12'hA5C});
    check("t2_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    check("t2_cmd_chan", 64'(cmd_chan), 64'd7);
    cs_end();

    // Abort after 5 data bits, then a fresh conversion on channel 2.
    ch_data[5*DW +: DW] = 12'hFFF;
    send_cmd(1'b1, 3'd5, 0);
    read_bits(6, v);
    check("t3_partial", v, 64'h1F);
    repeat (HALF) @(negedge clk);
    check("t3_so_before_abort", 64'(adc_so), 64'd1);
    adc_cs = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check("t3_so_after_abort", 64'(adc_so), 64'd0);
    check("t3_state_after_abort", 64'(dut.state_q), 64'(ST_IDLE));
    repeat (HALF) @(negedge clk);
    ch_data[2*DW +: DW] = 12'h3FF;
    send_cmd(1'b1, 3'd2, 0);
    read_bits(13, v);
    check("t3_second_word", v, {51'd0, 1'b0, 12'h3FF});
    check("t3_cmd_chan", 64'(cmd_chan), 64'd2);
    cs_end();

    // Differential channel 0; ch_data changes mid-word.
    ch_data[0 +: DW] = 12'h800;
    send_cmd(1'b0, 3'd0, 0);
    read_bits(4, v);
    ch_data[0 +: DW] = 12'h001;
    read_bits(10, v2);
    check("t4_frozen_word", {50'd0, v[3:0], v2[9:0]}, {50'd0, 1'b0, 12'h800, 1'b0});
    check("t4_cmd_sgl", 64'(cmd_sgl), 64'd0);
    check("t4_cmd_chan", 64'(cmd_chan), 64'd0);
    cs_end();

    // Channel 4 with 24 clocks past the null bit to exercise the trail.
    ch_data[4*DW +: DW] = 12'h801;
`ifdef ADC_RESP_LSB_TRAIL_EN
    exp6 = {39'd0, 1'b0, 12'h801, 11'b000_0000_0001, 1'b0};
`else
    exp6 = {39'd0, 1'b0, 12'h801, 12'h000};
`endif
    v0 = valid_cnt;
    send_cmd(1'b1, 3'd4, 0);
    read_bits(25, v);
    check("t5_word_and_trail", v, exp6);
    // Extra edges with si high must not restart a command.
    v2 = '0;
    for (int i = 0; i < 6; i++) begin
      sck_cycle(1'b1, b);
      v2 = {v2[62:0], b};
    end
    check("t5_trail_extra_so", v2, 64'd0);
    check("t5_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    check("t5_state_trail", 64'(dut.state_q), 64'(ST_TRAIL));
    cs_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
